// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: default widths and the
// bit positions of the status word {irq, frm_err, ovr_err, rd_valid}.
package uart_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    localparam int STAT_RD_VALID = 0;
    localparam int STAT_OVR_ERR  = 1;
    localparam int STAT_FRM_ERR  = 2;
    localparam int STAT_IRQ      = 3;
    localparam int STAT_W        = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: storage array, wrapping pointers, occupancy count
// and a registered head-of-queue output. Callers must not push when full or pop when empty.
module uart_rx_fifo import uart_pkg::*; #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [LW-1:0]     level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_inc;

    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign empty      = (level == '0);
    assign full       = (level == LW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // rd_data tracks the head so a byte is visible the cycle after it lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (!push && pop) begin
                level <= level - 1'b1;
            end
            // The incoming byte becomes the head when the queue is (or is about to be) empty.
            if (push && (empty || (pop && level == LW'(1)))) begin
                rd_data <= wr_data;
            end else if (pop) begin
                rd_data <= mem[rd_ptr_inc];
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// Receive-side buffer controller: qualifies receive-FSM strobes, queues bytes
// for the core, and keeps sticky error flags, a framing-error count and an irq.
module uart_rx_buffer_ctrl import uart_pkg::*; #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    CLOCK,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       rx_data,
    input  logic                    load_buffer,
    input  logic                    SFE,
    input  logic                    rx_enable,
    input  logic                    flush,
    input  logic                    clr_err,
    input  logic                    irq_en,
    input  logic                    rd_ack,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    ovr_err,
    output logic                    frm_err,
    output logic [CNT_W-1:0]        frm_cnt,
    output logic                    irq
);

    logic push_req;
    logic err_evt;
    logic pop;
    logic push;
    logic ovr_evt;
    logic full;
    logic empty;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A byte with a bad stop bit is reported as a framing error and never stored.
    assign push_req = rx_enable & load_buffer & ~SFE;
    assign err_evt  = rx_enable & SFE;
    assign pop      = rd_ack & ~empty;
    assign push     = push_req & (~full | pop);
    assign ovr_evt  = push_req & full & ~pop & ~flush;
    assign rd_valid = ~empty;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (CLOCK),
        .rst     (reset),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (rx_data),
        .rd_data (rd_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    // New error events take priority over a same-cycle clear.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            ovr_err <= 1'b0;
            frm_err <= 1'b0;
            frm_cnt <= '0;
        end else begin
            if (ovr_evt) begin
                ovr_err <= 1'b1;
            end else if (clr_err) begin
                ovr_err <= 1'b0;
            end
            if (err_evt) begin
                frm_err <= 1'b1;
                frm_cnt <= clr_err ? CNT_W'(1) : sat_inc(frm_cnt);
            end else if (clr_err) begin
                frm_err <= 1'b0;
                frm_cnt <= '0;
            end
        end
    end

    // Built from the registered status, so it trails it by one cycle.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en & (rd_valid | ovr_err | frm_err);
        end
    end

endmodule
